div_seq: RTL



---
 rtl/div_seq_pkg.sv | 22 ++
 rtl/div_seq_step.sv | 31 +++
 rtl/div_seq.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
// div_seq_pkg
// Shared definitions for the EX-stage divide sequencer:
//   - div_state_t  : FSM state encoding (IDLE/DIVZERO/ON/END)
//   - DIV_RESULT_READY / DIV_RESULT_NOT_READY : ready_o levels
//   - FUNCT_DIV / FUNCT_DIVU : MIPS SPECIAL funct codes that decode uses
//     to raise start_div and select signed_div_i.
package div_seq_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE    = 2'b00,
    DIV_DIVZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU = 6'b011011;

endpackage

// File: rtl/div_seq_step.sv
// div_step
// One restoring shift-subtract iteration (purely combinational).
// Ports:
//   rem          in  DIV_W  current partial remainder (always < divisor)
//   dividend_msb in  1      next dividend bit shifted into the remainder
//   divisor      in  DIV_W  divisor magnitude (non-zero)
//   rem_next     out DIV_W  partial remainder after this iteration
//   q_bit        out 1      quotient bit produced by this iteration
module div_step #(
  parameter int DIV_W = 32
) (
  input  logic [DIV_W-1:0] rem,
  input  logic             dividend_msb,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] rem_next,
  output logic             q_bit
);

  // The shifted remainder keeps the remainder's top bit: with an unsigned
  // divisor of 2^(DIV_W-1) or more the remainder can have its MSB set, and
  // dropping it would give wrong quotients. One extra bit makes the borrow
  // (bit DIV_W of the difference) an exact "shifted < divisor" flag.
  logic [DIV_W:0] shifted;
  logic [DIV_W:0] diff;

  assign shifted  = {rem, dividend_msb};
  assign diff     = shifted - {1'b0, divisor};
  assign q_bit    = ~diff[DIV_W];
  assign rem_next = q_bit ? diff[DIV_W-1:0] : shifted[DIV_W-1:0];

endmodule

// File: rtl/div_seq.sv
// div_seq
// Multi-cycle restoring divider for the EX stage. Accepts DIV/DIVU from
// decode, iterates DIV_W cycles, and stalls the pipeline until the result
// is ready. result_o = {remainder (HI), quotient (LO)}.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start_div      divide request, held high for the whole operation
//   signed_div_i   1 = DIV, 0 = DIVU (sampled at acceptance)
//   opdata1_i      dividend (sampled at acceptance)
//   opdata2_i      divisor  (sampled at acceptance)
//   annul_i        flush; aborts an in-flight divide
//   result_o       {remainder, quotient}, held until the next completion
//   ready_o        one-cycle pulse while result_o is freshly valid
//   stall_div_o    pipeline stall request
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DIV_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_div,
  input  logic               signed_div_i,
  input  logic [DIV_W-1:0]   opdata1_i,
  input  logic [DIV_W-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*DIV_W-1:0] result_o,
  output logic               ready_o,
  output logic               stall_div_o
);

  localparam int               CNT_W    = $clog2(DIV_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_W - 1);

  div_state_t         state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  // dq_reg starts as the dividend magnitude; each iteration shifts its MSB
  // into the remainder and a quotient bit into its LSB, so after DIV_W
  // iterations it holds the quotient. On the divide-by-zero path it keeps
  // the raw dividend for the remainder field.
  logic [DIV_W-1:0]   dq_reg, dq_next;
  logic [DIV_W-1:0]   divisor_reg, divisor_next;
  logic [DIV_W-1:0]   rem_reg, rem_next;
  logic               sign1_reg, sign1_next;
  logic               sign2_reg, sign2_next;
  logic               signed_reg, signed_next;
  logic [2*DIV_W-1:0] result_reg, result_next;
  logic               ready_reg, ready_next;

  logic [DIV_W-1:0]   step_rem;
  logic               step_q;
  logic [DIV_W-1:0]   quot_final;
  logic [DIV_W-1:0]   quot_fixed;
  logic [DIV_W-1:0]   rem_fixed;
  logic               abort;

  div_step #(
    .DIV_W(DIV_W)
  ) u_step (
    .rem          (rem_reg),
    .dividend_msb (dq_reg[DIV_W-1]),
    .divisor      (divisor_reg),
    .rem_next     (step_rem),
    .q_bit        (step_q)
  );

  assign abort = annul_i | ~start_div;

  // Result of the final iteration, computed in the last ON cycle so that
  // result_o and ready_o are registered on entry to END.
  assign quot_final = {dq_reg[DIV_W-2:0], step_q};
  assign quot_fixed = (signed_reg && (sign1_reg ^ sign2_reg)) ? -quot_final : quot_final;
  assign rem_fixed  = (signed_reg && sign1_reg) ? -step_rem : step_rem;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    dq_next      = dq_reg;
    divisor_next = divisor_reg;
    rem_next     = rem_reg;
    sign1_next   = sign1_reg;
    sign2_next   = sign2_reg;
    signed_next  = signed_reg;
    result_next  = result_reg;
    ready_next   = DIV_RESULT_NOT_READY;

    case (state_reg)
      DIV_IDLE: begin
        if (start_div && !annul_i) begin
          sign1_next  = opdata1_i[DIV_W-1];
          sign2_next  = opdata2_i[DIV_W-1];
          signed_next = signed_div_i;
          if (opdata2_i == '0) begin
            dq_next    = opdata1_i;
            state_next = DIV_DIVZERO;
          end else begin
            dq_next      = (signed_div_i && opdata1_i[DIV_W-1]) ? -opdata1_i : opdata1_i;
            divisor_next = (signed_div_i && opdata2_i[DIV_W-1]) ? -opdata2_i : opdata2_i;
            rem_next     = '0;
            cnt_next     = '0;
            state_next   = DIV_ON;
          end
        end
      end

      DIV_DIVZERO: begin
        if (abort) begin
          state_next = DIV_IDLE;
        end else begin
          result_next = {dq_reg, {DIV_W{1'b1}}};
          ready_next  = DIV_RESULT_READY;
          state_next  = DIV_END;
        end
      end

      DIV_ON: begin
        if (abort) begin
          state_next = DIV_IDLE;
        end else begin
          rem_next = step_rem;
          dq_next  = quot_final;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            result_next = {rem_fixed, quot_fixed};
            ready_next  = DIV_RESULT_READY;
            state_next  = DIV_END;
          end
        end
      end

      DIV_END: begin
        state_next = DIV_IDLE;
      end

      default: begin
        state_next = DIV_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= DIV_IDLE;
      cnt_reg     <= '0;
      dq_reg      <= '0;
      divisor_reg <= '0;
      rem_reg     <= '0;
      sign1_reg   <= 1'b0;
      sign2_reg   <= 1'b0;
      signed_reg  <= 1'b0;
      result_reg  <= '0;
      ready_reg   <= DIV_RESULT_NOT_READY;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      dq_reg      <= dq_next;
      divisor_reg <= divisor_next;
      rem_reg     <= rem_next;
      sign1_reg   <= sign1_next;
      sign2_reg   <= sign2_next;
      signed_reg  <= signed_next;
      result_reg  <= result_next;
      ready_reg   <= ready_next;
    end
  end

  assign result_o    = result_reg;
  assign ready_o     = ready_reg;
  assign stall_div_o = start_div & ~ready_reg & ~annul_i;

endmodule
